// File: rtl/alu_iterative.sv
// Multi-cycle RV32IM integer ALU: single-cycle ops finish one cycle after accept,
// while MUL/DIV/REM iterate one bit per cycle over magnitudes and apply the sign at the end.
module alu_iterative #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     busy
);

  localparam int N   = DATA_WIDTH;
  localparam int SHW = $clog2(DATA_WIDTH);

  localparam logic [OPCODE_LENGTH-1:0] OP_ADD   = OPCODE_LENGTH'(0);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB   = OPCODE_LENGTH'(1);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR   = OPCODE_LENGTH'(2);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR    = OPCODE_LENGTH'(3);
  localparam logic [OPCODE_LENGTH-1:0] OP_AND   = OPCODE_LENGTH'(4);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL   = OPCODE_LENGTH'(5);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL   = OPCODE_LENGTH'(6);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA   = OPCODE_LENGTH'(7);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT   = OPCODE_LENGTH'(8);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLTU  = OPCODE_LENGTH'(9);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ    = OPCODE_LENGTH'(10);
  localparam logic [OPCODE_LENGTH-1:0] OP_MUL   = OPCODE_LENGTH'(11);
  localparam logic [OPCODE_LENGTH-1:0] OP_MULH  = OPCODE_LENGTH'(12);
  localparam logic [OPCODE_LENGTH-1:0] OP_MULHU = OPCODE_LENGTH'(13);
  localparam logic [OPCODE_LENGTH-1:0] OP_DIV   = OPCODE_LENGTH'(14);
  localparam logic [OPCODE_LENGTH-1:0] OP_DIVU  = OPCODE_LENGTH'(15);
  localparam logic [OPCODE_LENGTH-1:0] OP_REM   = OPCODE_LENGTH'(16);
  localparam logic [OPCODE_LENGTH-1:0] OP_REMU  = OPCODE_LENGTH'(17);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                     state_q;
  logic [OPCODE_LENGTH-1:0]   op_q;
  logic [N-1:0]               opnd_q;    // multiplicand or divisor
  logic [N:0]                 hi_q;      // product high half or partial remainder
  logic [N-1:0]               lo_q;      // multiplier or dividend, shifted out one bit per step
  logic                       neg_q;
  logic [SHW-1:0]             cnt_q;
  logic [N-1:0]               result_q;
  logic                       in_ready_q;
  logic                       out_valid_q;
  logic                       busy_q;

  // Accept-time decode
  logic [SHW-1:0] shamt;
  logic           a_neg, b_neg, div_zero, div_ovf, is_mul, is_div, start_iter;
  logic [N-1:0]   a_mag, b_mag, simple_res, init_opnd, init_lo;
  logic           init_neg;

  always_comb begin
    shamt      = SrcB[SHW-1:0];
    a_neg      = SrcA[N-1];
    b_neg      = SrcB[N-1];
    a_mag      = a_neg ? -SrcA : SrcA;
    b_mag      = b_neg ? -SrcB : SrcB;
    div_zero   = (SrcB == '0);
    div_ovf    = (SrcA == {1'b1, {(N-1){1'b0}}}) && (SrcB == '1);
    is_mul     = (Operation == OP_MUL) || (Operation == OP_MULH) || (Operation == OP_MULHU);
    is_div     = (Operation == OP_DIV) || (Operation == OP_DIVU) ||
                 (Operation == OP_REM) || (Operation == OP_REMU);
    start_iter = is_mul || (is_div && !div_zero &&
                 !(div_ovf && ((Operation == OP_DIV) || (Operation == OP_REM))));

    simple_res = '0;
    case (Operation)
      OP_ADD:  simple_res = SrcA + SrcB;
      OP_SUB:  simple_res = SrcA - SrcB;
      OP_XOR:  simple_res = SrcA ^ SrcB;
      OP_OR:   simple_res = SrcA | SrcB;
      OP_AND:  simple_res = SrcA & SrcB;
      OP_SRL:  simple_res = SrcA >> shamt;
      OP_SLL:  simple_res = SrcA << shamt;
      OP_SRA:  simple_res = $signed(SrcA) >>> shamt;
      OP_SLT:  simple_res = {{(N-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      OP_SLTU: simple_res = {{(N-1){1'b0}}, SrcA < SrcB};
      OP_EQ:   simple_res = {{(N-1){1'b0}}, SrcA == SrcB};
      OP_DIV:  simple_res = div_zero ? '1 : (div_ovf ? SrcA : '0);
      OP_DIVU: simple_res = div_zero ? '1 : '0;
      OP_REM:  simple_res = div_zero ? SrcA : '0;
      OP_REMU: simple_res = div_zero ? SrcA : '0;
      default: simple_res = '0;
    endcase

    init_opnd = SrcA;
    init_lo   = SrcB;
    init_neg  = 1'b0;
    case (Operation)
      OP_MULH: begin
        init_opnd = a_mag;
        init_lo   = b_mag;
        init_neg  = a_neg ^ b_neg;
      end
      OP_DIV: begin
        init_opnd = b_mag;
        init_lo   = a_mag;
        init_neg  = a_neg ^ b_neg;
      end
      OP_REM: begin
        init_opnd = b_mag;
        init_lo   = a_mag;
        init_neg  = a_neg;   // remainder takes the dividend's sign
      end
      OP_DIVU, OP_REMU: begin
        init_opnd = SrcB;
        init_lo   = SrcA;
      end
      default: ;
    endcase
  end

  // One iteration step and the final sign-fixed result
  logic           op_is_mul;
  logic [N:0]     mul_sum, div_shift, div_diff, hi_d;
  logic           div_ge;
  logic [N-1:0]   lo_d, quo_s, rem_v, rem_s, iter_res;
  logic [2*N-1:0] prod, prod_s;

  always_comb begin
    op_is_mul = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_MULHU);
    mul_sum   = hi_q + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q[N-1:0], lo_q[N-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (op_is_mul) begin
      hi_d = {1'b0, mul_sum[N:1]};
      lo_d = {mul_sum[0], lo_q[N-1:1]};
    end else begin
      hi_d = div_ge ? div_diff : div_shift;
      lo_d = {lo_q[N-2:0], div_ge};
    end
    prod     = {hi_d[N-1:0], lo_d};
    prod_s   = neg_q ? -prod : prod;
    quo_s    = neg_q ? -lo_d : lo_d;
    rem_v    = hi_d[N-1:0];
    rem_s    = neg_q ? -rem_v : rem_v;
    iter_res = '0;
    case (op_q)
      OP_MUL:                    iter_res = prod_s[N-1:0];
      OP_MULH, OP_MULHU:         iter_res = prod_s[2*N-1:N];
      OP_DIV, OP_DIVU:           iter_res = quo_s;
      OP_REM, OP_REMU:           iter_res = rem_s;
      default:                   iter_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      opnd_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            op_q       <= Operation;
            opnd_q     <= init_opnd;
            lo_q       <= init_lo;
            hi_q       <= '0;
            neg_q      <= init_neg;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (start_iter) begin
              state_q <= S_RUN;
            end else begin
              state_q     <= S_DONE;
              result_q    <= simple_res;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + SHW'(1);
          // The last step writes the result directly, so RUN lasts exactly N cycles
          if (cnt_q == SHW'(N-1)) begin
            state_q     <= S_DONE;
            result_q    <= iter_res;
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign ALUResult = result_q;

endmodule

// File: tb/tb_alu_iterative.sv
// Bench for alu_iterative: directed corner cases plus random ops, checked against
// a plain-arithmetic reference model for both result and accept-to-valid latency.
module tb_alu_iterative;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic [4:0]  Operation = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] ALUResult;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  alu_iterative #(.DATA_WIDTH(32), .OPCODE_LENGTH(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUResult(ALUResult), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic div_special(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 5'd14 && op <= 5'd17 && b == 32'd0) return 1'b1;
    if ((op == 5'd14 || op == 5'd16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 5'd11 && op <= 5'd17 && !div_special(op, a, b)) return 33;
    return 1;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sp;
    logic [63:0] up;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = int'(a);
    ib = int'(b);
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a ^ b;
      5'd3:  return a | b;
      5'd4:  return a & b;
      5'd5:  return a >> b[4:0];
      5'd6:  return a << b[4:0];
      5'd7:  return $signed(a) >>> b[4:0];
      5'd8:  return (ia < ib) ? 32'd1 : 32'd0;
      5'd9:  return (a < b) ? 32'd1 : 32'd0;
      5'd10: return (a == b) ? 32'd1 : 32'd0;
      5'd11: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
      5'd12: begin sp = sa * sb; up = sp; return up[63:32]; end
      5'd13: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      5'd14: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      5'd15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd16: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      5'd17: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Drive one op, scramble inputs after accept, check latency/result, hold DONE, then handshake.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp_res;
    int          exp_lat;
    int          lat;
    exp_res = ref_alu(op, a, b);
    exp_lat = exp_latency(op, a, b);
    check_val("in_ready_before", {31'd0, in_ready}, 32'd1);
    SrcA = a; SrcB = b; Operation = op; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    SrcA = $urandom; SrcB = $urandom; Operation = 5'($urandom);
    in_valid = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom);
      SrcA = $urandom;
      lat++;
    end
    check_val("latency", lat, exp_lat);
    check_val("result", ALUResult, exp_res);
    check_val("busy_done", {31'd0, busy}, 32'd1);
    $display("txn op=%02h a=%h b=%h result=%h exp=%h lat=%0d", op, a, b, ALUResult, exp_res, lat);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; SrcA = $urandom; Operation = 5'd0;
      @(posedge clk); #1;
      check_val("hold_result", ALUResult, exp_res);
      check_val("hold_valid", {31'd0, out_valid}, 32'd1);
      check_val("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("post_valid", {31'd0, out_valid}, 32'd0);
    check_val("post_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("post_busy", {31'd0, busy}, 32'd0);
  endtask

  logic [31:0] edges [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  function automatic logic [31:0] pick_operand();
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    int          saw_valid;
    logic [4:0]  rop;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_result", ALUResult, 32'd0);

    run_op(5'd0,  32'h7FFF_FFFF, 32'h1, 0);
    run_op(5'd7,  32'h8000_0000, 32'd33, 0);
    run_op(5'd8,  32'hFFFF_FFFF, 32'h1, 0);
    run_op(5'd9,  32'hFFFF_FFFF, 32'h1, 0);
    run_op(5'd10, 32'd5, 32'd5, 0);
    run_op(5'h1F, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    run_op(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(5'd14, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(5'd16, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(5'd15, 32'd7, 32'd0, 0);
    run_op(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(5'd12, 32'h8000_0000, 32'h0000_0003, 0);
    run_op(5'd1,  32'h0000_0010, 32'h0000_0020, 10);

    // Reset in the middle of RUN drops the op
    SrcA = 32'h1234_5678; SrcB = 32'h0000_0101; Operation = 5'd11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_val("midrun_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("midrun_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("midrun_busy", {31'd0, busy}, 32'd0);
    check_val("midrun_result", ALUResult, 32'd0);
    saw_valid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid++;
    end
    check_val("midrun_no_output", saw_valid, 32'd0);
    run_op(5'd0, 32'd100, 32'd23, 0);

    for (int n = 0; n < 50; n++) begin
      rop = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 17));
      run_op(rop, pick_operand(), pick_operand(), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
